ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_pkg.sv | 20 ++
 rtl/ifq_fifo.sv | 47 ++++
 rtl/ifetch_queue.sv | 125 ++++++++++++
 tb/tb_ifetch_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
package ifetch_queue_pkg;

  localparam int IFQ_PC_W   = 9;
  localparam int IFQ_INS_W  = 32;
  localparam int IFQ_PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } ifq_state_t;

  // Entry width follows the package widths; the top-level PC_W/INS_W must match them.
  typedef struct packed {
    logic [IFQ_PC_W-1:0]  pc;
    logic [IFQ_INS_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - circular buffer with occupancy count, flush, push and pop
module ifq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Flush outranks push and pop so a same-cycle enqueue never survives a clear.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch request generator with in-order prefetch queue toward IF/ID
// Optional IFQ_BYPASS_EN forwards a response straight to IF/ID when the queue is empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int PC_W  = IFQ_PC_W,
  parameter int INS_W = IFQ_INS_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  input  logic             if_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(ifq_entry_t);

  ifq_state_t      state;
  logic [PC_W-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   t_count;
  logic            q_empty;
  logic            t_empty;
  logic [PC_W-1:0] t_head;
  ifq_entry_t      rsp_entry;
  ifq_entry_t      q_head;
  ifq_entry_t      head;
  logic            fire;
  logic            rsp_take;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            q_push;
  logic            q_pop;
  logic [CW:0]     outstanding;
  logic [CW:0]     in_flight;
  logic [CW:0]     out_next;

  // The tracker is cleared on redirect, so requests still in flight are those it holds plus those marked for dropping.
  assign outstanding = {1'b0, t_count} + {1'b0, drop_cnt};
  assign in_flight   = {1'b0, q_count} + outstanding;
  assign out_next    = outstanding + {{CW{1'b0}}, fire} - {{CW{1'b0}}, rsp_take};

  assign imem_req_valid = !reset && (state == RUN) && (in_flight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  // With nothing in flight a response can only belong to a request issued before reset.
  assign rsp_take  = imem_rsp_valid && !reset && (drop_cnt != '0 || !t_empty);
  assign rsp_drop  = rsp_take && (redirect || drop_cnt != '0);
  assign rsp_keep  = rsp_take && !rsp_drop;
  assign rsp_entry = '{pc: t_head, instr: imem_rsp_data};

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass   = rsp_keep && q_empty;
  assign q_push   = rsp_keep && !(bypass && if_ready);
  assign if_valid = !reset && (!q_empty || bypass);
  assign head     = q_empty ? rsp_entry : q_head;
  assign q_pop    = if_valid && if_ready && !redirect && !q_empty;
`else
  assign q_push   = rsp_keep;
  assign if_valid = !reset && !q_empty;
  assign head     = q_head;
  assign q_pop    = if_valid && if_ready && !redirect;
`endif

  assign if_pc    = if_valid ? head.pc : '0;
  assign if_instr = if_valid ? head.instr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      fetch_pc <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      drop_cnt <= out_next[CW-1:0];
      state    <= (out_next != '0) ? FLUSH : RUN;
    end else begin
      if (fire)     fetch_pc <= fetch_pc + PC_W'(IFQ_PC_INC);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      case (state)
        BOOT:    state <= RUN;
        FLUSH:   if (rsp_drop && drop_cnt == CW'(1)) state <= RUN;
        default: state <= state;
      endcase
    end
  end

  ifq_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (t_head),
    .count     (t_count),
    .empty     (t_empty)
  );

  ifq_fifo #(.W(EW), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (q_push),
    .push_data (rsp_entry),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed vector and sequence bench for ifetch_queue
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [8:0]  imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        if_valid;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  ifetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a;
    int         due;
  } mreq_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       rd;
    logic [8:0] rpc;
    logic       xreq;
    logic [8:0] xaddr;
    logic       xval;
    logic [8:0] xpc;
    logic       cpc;
  } vec_t;

  mreq_t mq[$];
  vec_t  tv[18];
  int    cyc = 0;
  int    lat = 1;
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] mem_f(input logic [8:0] a);
    return {16'hC0DE, 7'd0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: capture handshakes, advance the in-order memory model, let outputs settle.
  task automatic tick();
    logic       f;
    logic       r;
    logic [8:0] fa;
    f  = imem_req_valid && imem_req_ready;
    fa = imem_req_addr;
    r  = imem_rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (f) mq.push_back('{a: fa, due: cyc - 1 + lat});
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(mq[0].a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset(input int n, input bit clear);
    reset    = 1'b1;
    redirect = 1'b0;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    if (clear) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic expect_pc(input logic [8:0] pc, input string name);
    int n = 0;
    while (!(if_valid && if_ready) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (!(if_valid && if_ready)) begin
      errors++;
      $display("FAIL %s: got no delivery expected pc %0h", name, pc);
    end else begin
      chk({name, "_pc"}, {23'd0, if_pc}, {23'd0, pc});
      chk({name, "_instr"}, if_instr, mem_f(pc));
      tick();
    end
  endtask

  initial begin
    int nfire;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    //        rst rdy rd rpc     xreq xaddr   xval xpc     cpc
    tv[0]  = '{1, 1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 1};
    tv[1]  = '{1, 1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 1};
    tv[2]  = '{0, 1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 1};
    tv[3]  = '{0, 1, 0, 9'h000, 1, 9'h000, 0, 9'h000, 0};
    tv[4]  = '{0, 1, 0, 9'h000, 1, 9'h004, 0, 9'h000, 0};
    tv[5]  = '{0, 1, 0, 9'h000, 1, 9'h008, 1, 9'h000, 1};
    tv[6]  = '{0, 1, 0, 9'h000, 1, 9'h00C, 1, 9'h004, 1};
    tv[7]  = '{0, 1, 1, 9'h100, 1, 9'h010, 1, 9'h008, 1};
    tv[8]  = '{0, 1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 0};
    tv[9]  = '{0, 1, 0, 9'h000, 1, 9'h100, 0, 9'h000, 0};
    tv[10] = '{0, 1, 0, 9'h000, 1, 9'h104, 0, 9'h000, 0};
    tv[11] = '{0, 1, 0, 9'h000, 1, 9'h108, 1, 9'h100, 1};
    tv[12] = '{0, 0, 0, 9'h000, 1, 9'h10C, 1, 9'h104, 1};
    tv[13] = '{0, 0, 0, 9'h000, 1, 9'h110, 1, 9'h104, 1};
    tv[14] = '{0, 0, 0, 9'h000, 0, 9'h000, 1, 9'h104, 1};
    tv[15] = '{0, 0, 0, 9'h000, 0, 9'h000, 1, 9'h104, 1};
    tv[16] = '{0, 1, 0, 9'h000, 0, 9'h000, 1, 9'h104, 1};
    tv[17] = '{0, 1, 0, 9'h000, 1, 9'h114, 1, 9'h108, 1};

    for (int i = 0; i < 18; i++) begin
      reset = tv[i].rst; if_ready = tv[i].rdy;
      redirect = tv[i].rd; redirect_pc = tv[i].rpc;
      #1;
      chk($sformatf("row%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tv[i].xreq});
      if (tv[i].xreq)
        chk($sformatf("row%0d_req_addr", i), {23'd0, imem_req_addr}, {23'd0, tv[i].xaddr});
      chk($sformatf("row%0d_if_valid", i), {31'd0, if_valid}, {31'd0, tv[i].xval});
      if (tv[i].cpc)
        chk($sformatf("row%0d_if_pc", i), {23'd0, if_pc}, {23'd0, tv[i].xpc});
      tick();
    end
    redirect = 1'b0;

    // Consumer stalled: exactly DEPTH requests, then a gapless in-order drain.
    do_reset(2, 1'b1);
    lat = 1; if_ready = 1'b0; nfire = 0; #1;
    repeat (10) begin
      nfire += int'(imem_req_valid && imem_req_ready);
      tick();
    end
    chk("stall_req_count", nfire, 4);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 0);
    if_ready = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), {31'd0, if_valid}, 1);
      chk($sformatf("drain%0d_pc", k), {23'd0, if_pc}, k * 4);
      tick();
    end

    // Redirect with two responses outstanding: both must be dropped.
    do_reset(2, 1'b1);
    lat = 3;
    for (int n = 0; n < 20 && mq.size() != 2; n++) tick();
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 9'h100; #1;
    tick();
    redirect = 1'b0; imem_req_ready = 1'b1; #1;
    chk("b_if_valid_after_redirect", {31'd0, if_valid}, 0);
    chk("b_flush_no_req", {31'd0, imem_req_valid}, 0);
    expect_pc(9'h100, "b_first");
    expect_pc(9'h104, "b_second");
    expect_pc(9'h108, "b_third");

    // Redirect colliding with a response and an output handshake.
    do_reset(2, 1'b1);
    lat = 1;
    repeat (6) tick();
    chk("c_precondition", {31'd0, if_valid && imem_rsp_valid}, 1);
    redirect = 1'b1; redirect_pc = 9'h040; #1;
    tick();
    redirect = 1'b0; #1;
    chk("c_if_valid_after_redirect", {31'd0, if_valid}, 0);
    expect_pc(9'h040, "c_first");
    expect_pc(9'h044, "c_second");

    // Fetch address wraps at the top of the PC range.
    redirect = 1'b1; redirect_pc = 9'h1F8; #1;
    tick();
    redirect = 1'b0; #1;
    expect_pc(9'h1F8, "d_1f8");
    expect_pc(9'h1FC, "d_1fc");
    expect_pc(9'h000, "d_wrap");

    // Reset in the middle of a flush: late responses land during reset and boot.
    do_reset(2, 1'b1);
    lat = 4;
    repeat (8) tick();
    redirect = 1'b1; redirect_pc = 9'h080; #1;
    tick();
    redirect = 1'b0; #1;
    chk("e_flush_no_req", {31'd0, imem_req_valid}, 0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("e_rst%0d_req_valid", k), {31'd0, imem_req_valid}, 0);
      chk($sformatf("e_rst%0d_if_valid", k), {31'd0, if_valid}, 0);
      tick();
    end
    reset = 1'b0; #1;
    chk("e_boot_req_valid", {31'd0, imem_req_valid}, 0);
    chk("e_boot_if_pc", {23'd0, if_pc}, 0);
    expect_pc(9'h000, "e_first");
    expect_pc(9'h004, "e_second");
    expect_pc(9'h008, "e_third");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
